// File: rtl/code_sender.sv
// code_sender: initiator side of the scanner code interface.
// Latches an access code on start, presents it to the scanner with enable held
// high, and waits for code_valid. A timed-out attempt drops enable for GAP_CYC
// cycles so the scanner re-arms, then retries up to MAX_RETRY times. The transfer
// ends with a one-cycle done (accepted) or error (all attempts timed out) pulse.
//
// Ports:
//   clk, rst_n    clock, asynchronous active-low reset
//   start_i       request a transfer (sampled only while idle)
//   abort_i       cancel any transfer, return to idle (priority over start_i)
//   code_in_i     code to send, sampled on the accepting start edge
//   code_valid_i  scanner acknowledge
//   enable_o      scanner enable
//   code_o        latched code while sending, else 0
//   busy_o        high while a transfer is in progress
//   done_o        one-cycle pulse: code accepted
//   error_o       one-cycle pulse: all attempts timed out
//   attempts_o    retries used; held until the next accepted start
module code_sender #(
  parameter int unsigned CODE_W    = 4,
  parameter int unsigned TIMEOUT   = 8,
  parameter int unsigned MAX_RETRY = 2,
  parameter int unsigned GAP_CYC   = 1,
  localparam int unsigned ATT_W    = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start_i,
  input  logic              abort_i,
  input  logic [CODE_W-1:0] code_in_i,
  input  logic              code_valid_i,
  output logic              enable_o,
  output logic [CODE_W-1:0] code_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              error_o,
  output logic [ATT_W-1:0]  attempts_o
);

  // One counter serves both the SEND timeout and the GAP length.
  localparam int unsigned CNT_MAX = (TIMEOUT > GAP_CYC) ? TIMEOUT : GAP_CYC;
  localparam int unsigned CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SEND,
    S_GAP,
    S_DONE,
    S_FAIL
  } state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ATT_W-1:0]  att_q, att_d;
  logic [CODE_W-1:0] latch_q, latch_d;

  logic              enable_q, enable_d;
  logic [CODE_W-1:0] code_q, code_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              error_q, error_d;

  // Next-state logic; outputs are decoded from the next state so they line up
  // with the state they describe once registered.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    att_d   = att_q;
    latch_d = latch_q;

    unique case (state_q)
      S_IDLE: begin
        if (start_i && !abort_i) begin
          latch_d = code_in_i;
          att_d   = '0;
          cnt_d   = '0;
          state_d = S_SEND;
        end
      end
      S_SEND: begin
        if (abort_i) begin
          cnt_d   = '0;
          state_d = S_IDLE;
        end else if (code_valid_i) begin
          // An ack on the timeout edge still counts as accepted.
          cnt_d   = '0;
          state_d = S_DONE;
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          cnt_d   = '0;
          state_d = (att_q < ATT_W'(MAX_RETRY)) ? S_GAP : S_FAIL;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_GAP: begin
        if (abort_i) begin
          cnt_d   = '0;
          state_d = S_IDLE;
        end else if (cnt_q == CNT_W'(GAP_CYC - 1)) begin
          cnt_d   = '0;
          att_d   = att_q + ATT_W'(1);
          state_d = S_SEND;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_DONE:  state_d = S_IDLE;
      S_FAIL:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    enable_d = (state_d == S_SEND);
    code_d   = enable_d ? latch_d : '0;
    busy_d   = (state_d != S_IDLE);
    done_d   = (state_d == S_DONE);
    error_d  = (state_d == S_FAIL);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      att_q    <= '0;
      latch_q  <= '0;
      enable_q <= 1'b0;
      code_q   <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      error_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      att_q    <= att_d;
      latch_q  <= latch_d;
      enable_q <= enable_d;
      code_q   <= code_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      error_q  <= error_d;
    end
  end

  assign enable_o   = enable_q;
  assign code_o     = code_q;
  assign busy_o     = busy_q;
  assign done_o     = done_q;
  assign error_o    = error_q;
  assign attempts_o = att_q;

endmodule

// File: tb/tb_code_sender.sv
// tb_code_sender: self-checking bench for code_sender.
// A scanner model acknowledges after a chosen number of enabled cycles per
// attempt; expected outcomes come from a table of constants and, for random
// transfers, from an arithmetic model of attempts, windows and gaps.
module tb_code_sender;

  localparam int unsigned CODE_W    = 4;
  localparam int unsigned TIMEOUT   = 8;
  localparam int unsigned MAX_RETRY = 2;
  localparam int unsigned GAP_CYC   = 1;
  localparam int unsigned ATT_W     = $clog2(MAX_RETRY + 1);
  localparam int          NEVER     = 99;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              start;
  logic              abort;
  logic [CODE_W-1:0] code_in;
  logic              code_valid;
  logic              enable;
  logic [CODE_W-1:0] code;
  logic              busy;
  logic              done;
  logic              error;
  logic [ATT_W-1:0]  attempts;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  code_sender #(
    .CODE_W   (CODE_W),
    .TIMEOUT  (TIMEOUT),
    .MAX_RETRY(MAX_RETRY),
    .GAP_CYC  (GAP_CYC)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start_i     (start),
    .abort_i     (abort),
    .code_in_i   (code_in),
    .code_valid_i(code_valid),
    .enable_o    (enable),
    .code_o      (code),
    .busy_o      (busy),
    .done_o      (done),
    .error_o     (error),
    .attempts_o  (attempts)
  );

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  typedef struct {
    logic [CODE_W-1:0] c;
    int                ak0;
    int                ak1;
    int                ak2;
    bit                noise;
    int                e_done;
    int                e_err;
    int                e_att;
    int                e_busy;
  } vec_t;

  // Outcome of a transfer where attempt a is acked after ak[a] enabled cycles.
  function automatic void predict(input int ak[3], output int d, output int e,
                                  output int a, output int b, output int w);
    b = 0;
    for (int i = 0; i <= int'(MAX_RETRY); i++) begin
      if (ak[i] >= 1 && ak[i] <= int'(TIMEOUT)) begin
        d = 1; e = 0; a = i; w = i + 1;
        b = b + ak[i] + 1;
        return;
      end
      b = b + int'(TIMEOUT) + ((i < int'(MAX_RETRY)) ? int'(GAP_CYC) : 0);
    end
    d = 0; e = 1; a = int'(MAX_RETRY); w = int'(MAX_RETRY) + 1;
    b = b + 1;
  endfunction

  // Runs one transfer with the scanner model; observes on falling edges.
  task automatic run_txn(input logic [CODE_W-1:0] c, input int ak0, input int ak1,
                         input int ak2, input bit noise,
                         output int n_done, output int n_err, output int busy_cnt,
                         output int bad, output int done_at, output int n_win);
    int  ak[3];
    int  ec;
    int  att;
    bit  prev_en;
    bit  ended;
    ak = '{ak0, ak1, ak2};
    n_done = 0; n_err = 0; busy_cnt = 0; bad = 0; done_at = -1; n_win = 0;
    ec = 0; att = 0; prev_en = 1'b0; ended = 1'b0;
    @(negedge clk);
    start = 1'b1; code_in = c; abort = 1'b0; code_valid = 1'b0;
    @(negedge clk);
    start = 1'b0;
    for (int n = 0; n < 200; n++) begin
      if (!busy) begin
        ended = 1'b1;
        break;
      end
      busy_cnt++;
      if (done) begin
        n_done++;
        if (done_at < 0) done_at = n;
      end
      if (error) n_err++;
      if (done && error) bad++;
      if (enable) begin
        if (!prev_en) n_win++;
        ec++;
        if (code !== c) bad++;
      end else begin
        if (code !== '0) bad++;
        if (prev_en && !done) begin
          att++;
          ec = 0;
        end
      end
      prev_en = enable;
      code_valid = enable ? ((att < 3) ? (ec == ak[att]) : 1'b0)
                          : 1'($urandom_range(0, 1));
      start   = noise;
      code_in = noise ? CODE_W'(4'h5) : c;
      @(negedge clk);
    end
    start = 1'b0; code_valid = 1'b0; code_in = c;
    check("txn_ends", int'(ended), 1);
  endtask

  task automatic check_txn(input string tag, input logic [CODE_W-1:0] c,
                           input int ak0, input int ak1, input int ak2, input bit noise,
                           input int e_done, input int e_err, input int e_att,
                           input int e_busy, input int e_win);
    int d, e, b, bad, dat, w;
    run_txn(c, ak0, ak1, ak2, noise, d, e, b, bad, dat, w);
    check({tag, "_done"}, d, e_done);
    check({tag, "_error"}, e, e_err);
    check({tag, "_attempts"}, int'(attempts), e_att);
    check({tag, "_busy_cycles"}, b, e_busy);
    check({tag, "_windows"}, w, e_win);
    check({tag, "_code_bad_cycles"}, bad, 0);
    check({tag, "_done_at"}, dat, (e_done != 0) ? e_busy - 1 : -1);
  endtask

  initial begin
    vec_t vecs[7];
    int   d, e, a, b, w;
    int   ak[3];
    int   pulses;

    vecs[0] = '{4'b1011, 5,     NEVER, NEVER, 1'b0, 1, 0, 0, 6};
    vecs[1] = '{4'b1011, NEVER, NEVER, NEVER, 1'b0, 0, 1, 2, 27};
    vecs[2] = '{4'b1011, NEVER, 3,     NEVER, 1'b0, 1, 0, 1, 13};
    vecs[3] = '{4'b1011, 8,     NEVER, NEVER, 1'b0, 1, 0, 0, 9};
    vecs[4] = '{4'b1011, 5,     NEVER, NEVER, 1'b1, 1, 0, 0, 6};
    vecs[5] = '{4'b0110, NEVER, NEVER, 8,     1'b0, 1, 0, 2, 27};
    vecs[6] = '{4'b1100, NEVER, NEVER, 1,     1'b0, 1, 0, 2, 20};

    rst_n = 1'b0; start = 1'b0; abort = 1'b0; code_in = '0; code_valid = 1'b0;
    #12;
    check("rst_enable", int'(enable), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_code", int'(code), 0);
    check("rst_done_error", int'({done, error}), 0);
    check("rst_attempts", int'(attempts), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Reset in the middle of a send window.
    @(negedge clk);
    start = 1'b1; code_in = 4'b1011;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    check("pre_rst_enable", int'(enable), 1);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_enable", int'(enable), 0);
    check("async_rst_code", int'(code), 0);
    check("async_rst_busy", int'(busy), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_idle", int'(busy), 0);

    // Table of directed transfers.
    for (int i = 0; i < 7; i++) begin
      predict('{vecs[i].ak0, vecs[i].ak1, vecs[i].ak2}, d, e, a, b, w);
      check_txn($sformatf("vec%0d", i), vecs[i].c, vecs[i].ak0, vecs[i].ak1, vecs[i].ak2,
                vecs[i].noise, vecs[i].e_done, vecs[i].e_err, vecs[i].e_att,
                vecs[i].e_busy, w);
    end

    // Abort on the third SEND cycle.
    @(negedge clk);
    start = 1'b1; code_in = 4'b1011;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort_enable", int'(enable), 0);
    check("abort_busy", int'(busy), 0);
    check("abort_code", int'(code), 0);
    check("abort_attempts", int'(attempts), 0);
    pulses = int'(done) + int'(error);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      pulses += int'(done) + int'(error) + int'(busy);
    end
    check("abort_no_pulse", pulses, 0);

    // Abort wins over start while idle.
    start = 1'b1; abort = 1'b1; code_in = 4'b0001;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    check("abort_over_start", int'(busy), 0);

    check_txn("after_abort", 4'b1011, 2, NEVER, NEVER, 1'b0, 1, 0, 0, 3, 1);

    // Randomized transfers against the arithmetic model.
    for (int i = 0; i < 40; i++) begin
      logic [CODE_W-1:0] c;
      bit nz;
      c = CODE_W'($urandom);
      nz = 1'($urandom_range(0, 1));
      for (int k = 0; k < 3; k++)
        ak[k] = ($urandom_range(0, 2) == 0) ? NEVER : int'($urandom_range(1, TIMEOUT));
      predict(ak, d, e, a, b, w);
      check_txn($sformatf("rnd%0d", i), c, ak[0], ak[1], ak[2], nz, d, e, a, b, w);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
